// File: rtl/mult_requester_pkg.sv
// Shared types and constants for the multiplier requester: FSM state encoding
// and the WAIT-state timeout derived from the operand width.
package mult_requester_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    // A healthy multiplier answers well within 2^WIDTH cycles; the +4 gives slack.
    function automatic int unsigned timeout_cycles(input int unsigned width);
        return (32'd1 << width) + 32'd4;
    endfunction

endpackage

// File: rtl/mult_requester_fifo.sv
// Operand-pair FIFO: DEPTH entries of {a, b}, wrap-bit pointers, registered storage.
module mult_requester_fifo
    import mult_requester_pkg::*;
#(
    parameter int WIDTH = 5,
    parameter int DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic [2*WIDTH-1:0] push_data,
    input  logic               pop,
    output logic               full,
    output logic               empty,
    output logic [2*WIDTH-1:0] head
);

    localparam int AW = $clog2(DEPTH);

    logic [2*WIDTH-1:0] mem [DEPTH];
    logic [AW:0]        wr_ptr;
    logic [AW:0]        rd_ptr;
    logic               do_push;
    logic               do_pop;

    // Full is judged before any same-cycle pop, so a full FIFO never takes a push.
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/mult_requester.sv
// Queues operand pairs, issues them one at a time to an external multiplier,
// and returns {a, b, a*b} on a valid/ready output with a sticky timeout flag.
module mult_requester
    import mult_requester_pkg::*;
#(
    parameter int WIDTH = 5,
    parameter int DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    output logic               m_req,
    input  logic               m_rdy,
    output logic [WIDTH-1:0]   m_a,
    output logic [WIDTH-1:0]   m_b,
    input  logic               m_done,
    input  logic [2*WIDTH-1:0] m_ab,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_a,
    output logic [WIDTH-1:0]   out_b,
    output logic [2*WIDTH-1:0] out_ab,
    output logic               timeout_err,
    output logic [15:0]        op_count,
    output state_t             fsm_state
);

    // Handshakes: a transfer happens on a rising edge where valid & ready are
    // both high (in_valid/in_ready, m_req/m_rdy, out_valid/out_ready); the
    // offering side holds valid and its payload stable until that edge.

    localparam int unsigned TIMEOUT = timeout_cycles(WIDTH);
    localparam int          CW      = $clog2(TIMEOUT + 1);

    state_t             state;
    state_t             state_next;
    logic               fifo_full;
    logic               fifo_empty;
    logic [2*WIDTH-1:0] fifo_head;
    logic               pop;
    logic               load_issue;
    logic               load_result;
    logic               set_err;
    logic               out_fire;
    logic [CW-1:0]      wait_cnt;

    mult_requester_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (in_valid),
        .push_data ({in_a, in_b}),
        .pop       (pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (fifo_head)
    );

    assign in_ready  = !fifo_full;
    assign m_req     = (state == REQ);
    assign out_fire  = out_valid && out_ready;
    assign fsm_state = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next  = state;
        load_issue  = 1'b0;
        pop         = 1'b0;
        load_result = 1'b0;
        set_err     = 1'b0;
        case (state)
            IDLE: begin
                // Only issue when the output slot is free or being freed now.
                if (!fifo_empty && (!out_valid || out_ready)) begin
                    state_next = REQ;
                    load_issue = 1'b1;
                end
            end
            REQ: begin
                if (m_rdy) begin
                    pop        = 1'b1;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (m_done) begin
                    load_result = 1'b1;
                    state_next  = IDLE;
                end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
                    set_err    = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (state == WAIT) begin
            wait_cnt <= wait_cnt + CW'(1);
        end else begin
            wait_cnt <= '0;
        end
    end

    // The head cannot change while in REQ, so latching it on entry keeps
    // m_a/m_b equal to the head during REQ and holding afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_a <= '0;
            m_b <= '0;
        end else if (load_issue) begin
            m_a <= fifo_head[2*WIDTH-1:WIDTH];
            m_b <= fifo_head[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_a     <= '0;
            out_b     <= '0;
            out_ab    <= '0;
        end else if (load_result) begin
            out_valid <= 1'b1;
            out_a     <= m_a;
            out_b     <= m_b;
            out_ab    <= m_ab;
        end else if (out_fire) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timeout_err <= 1'b0;
            op_count    <= '0;
        end else begin
            if (set_err)  timeout_err <= 1'b1;
            if (out_fire) op_count    <= op_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_mult_requester.sv
// Directed + randomized bench for mult_requester with a behavioural multiplier
// and a scoreboard of expected {a, b, a*b} results in acceptance order.
module tb_mult_requester;
    import mult_requester_pkg::*;

    localparam int W     = 5;
    localparam int RW    = 2 * W;
    localparam int DEPTH = 4;
    localparam int TMO   = int'(timeout_cycles(W));

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_a;
    logic [W-1:0]  in_b;
    logic          m_req;
    logic          m_rdy;
    logic [W-1:0]  m_a;
    logic [W-1:0]  m_b;
    logic          m_done;
    logic [RW-1:0] m_ab;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_a;
    logic [W-1:0]  out_b;
    logic [RW-1:0] out_ab;
    logic          timeout_err;
    logic [15:0]   op_count;
    state_t        fsm_state;

    mult_requester #(.WIDTH(W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .m_req(m_req), .m_rdy(m_rdy), .m_a(m_a), .m_b(m_b),
        .m_done(m_done), .m_ab(m_ab),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_a(out_a), .out_b(out_b), .out_ab(out_ab),
        .timeout_err(timeout_err), .op_count(op_count), .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    // Scoreboard and stimulus state.
    logic [4*W-1:0] exp_q[$];
    logic [2*W-1:0] pend_q[$];
    int n_cmp   = 0;
    int n_bad   = 0;
    int got     = 0;
    int starts  = 0;
    int exp_cnt = 0;
    bit rdy_rand = 1'b0;
    bit ord_rand = 1'b0;
    bit hang     = 1'b0;

    // Behavioural multiplier: random latency, occasional stray m_done when idle.
    initial begin : mult_model
        logic [W-1:0] ma, mb;
        int lat;
        m_done = 1'b0;
        m_ab   = '0;
        forever begin
            @(negedge clk);
            if (m_req && m_rdy && !rst) begin
                ma = m_a;
                mb = m_b;
                @(posedge clk); #1;
                m_done = 1'b0;
                if (!hang) begin
                    lat = $urandom_range(1, 4);
                    repeat (lat - 1) begin @(posedge clk); #1; end
                    m_done = 1'b1;
                    m_ab   = RW'(ma) * RW'(mb);
                    @(posedge clk); #1;
                    m_done = 1'b0;
                    m_ab   = RW'($urandom);
                end
            end else begin
                @(posedge clk); #1;
                m_done = !hang && ($urandom_range(0, 7) == 0);
                m_ab   = RW'($urandom);
            end
        end
    end

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_in();
        if (pend_q.size() > 0) begin
            in_valid = 1'b1;
            in_a     = pend_q[0][2*W-1:W];
            in_b     = pend_q[0][W-1:0];
        end else begin
            in_valid = 1'b0;
        end
    endtask

    task automatic enq(input logic [W-1:0] a, input logic [W-1:0] b);
        pend_q.push_back({a, b});
        drive_in();
    endtask

    // One clock: sample handshakes on the falling edge, update inputs after the rising edge.
    task automatic step();
        logic [4*W-1:0] e;
        logic           pushed;
        @(negedge clk);
        if (m_req && m_rdy) starts++;
        if (out_valid && out_ready) begin
            got++;
            exp_cnt++;
            if (exp_q.size() == 0) begin
                check("unexpected_result", 32'(out_ab), 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("out_a", 32'(out_a), 32'(e[4*W-1:3*W]));
                check("out_b", 32'(out_b), 32'(e[3*W-1:2*W]));
                check("out_ab", 32'(out_ab), 32'(e[RW-1:0]));
                check("op_count_before_accept", 32'(op_count), 32'(16'(exp_cnt - 1)));
            end
        end
        pushed = in_valid && in_ready;
        if (pushed) exp_q.push_back({in_a, in_b, RW'(in_a) * RW'(in_b)});
        @(posedge clk); #1;
        if (pushed) void'(pend_q.pop_front());
        drive_in();
        if (rdy_rand) m_rdy = ($urandom_range(0, 3) != 0);
        if (ord_rand) out_ready = ($urandom_range(0, 2) != 0);
    endtask

    task automatic drain(input int n, input int budget);
        int target;
        int t;
        target = got + n;
        t = 0;
        while (got < target && t < budget) begin
            step();
            t++;
        end
        check("drain_results", 32'(got), 32'(target));
    endtask

    initial begin : main
        int s0;
        int g0;
        int t;
        int n;
        logic [W-1:0] ha, hb;

        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0;
        m_rdy = 1'b0; out_ready = 1'b0;

        // Reset values.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_m_req", 32'(m_req), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_op_count", 32'(op_count), 32'd0);
        check("rst_timeout_err", 32'(timeout_err), 32'd0);
        check("rst_m_a", 32'(m_a), 32'd0);
        check("rst_out_ab", 32'(out_ab), 32'd0);
        check("rst_state", 32'(fsm_state), 32'(IDLE));
        @(posedge clk); #1;
        rst = 1'b0;

        // Basic product (3,7) with a ready consumer.
        rdy_rand = 1'b1; out_ready = 1'b1;
        enq(5'd3, 5'd7);
        drain(1, 60);
        check("basic_op_count", 32'(op_count), 32'd1);
        check("basic_out_valid_cleared", 32'(out_valid), 32'd0);

        // Zero operand and maximum operands.
        enq(5'd0, 5'd9);
        drain(1, 60);
        enq(5'd31, 5'd31);
        drain(1, 60);
        check("max_no_timeout", 32'(timeout_err), 32'd0);
        check("max_op_count", 32'(op_count), 32'(16'(exp_cnt)));

        // Backpressure: six pairs with the consumer stalled.
        out_ready = 1'b0; rdy_rand = 1'b0; m_rdy = 1'b1;
        for (int i = 0; i < 6; i++) enq(W'($urandom), W'($urandom));
        g0 = got;
        repeat (30) step();
        check("bp_no_results", 32'(got), 32'(g0));
        check("bp_in_ready_low", 32'(in_ready), 32'd0);
        check("bp_one_pending", 32'(pend_q.size()), 32'd1);
        check("bp_out_valid_held", 32'(out_valid), 32'd1);
        check("bp_out_ab_held", 32'(out_ab), 32'(exp_q[0][RW-1:0]));
        out_ready = 1'b1;
        drain(6, 200);
        check("bp_all_in", 32'(pend_q.size()), 32'd0);

        // m_rdy held low: m_req and operands must hold, then exactly one start.
        m_rdy = 1'b0;
        s0 = starts;
        enq(5'd13, 5'd22);
        t = 0;
        while (!m_req && t < 10) begin step(); t++; end
        check("stall_m_req_seen", 32'(m_req), 32'd1);
        for (int i = 0; i < 10; i++) begin
            step();
            check("stall_m_req_high", 32'(m_req), 32'd1);
            check("stall_m_a", 32'(m_a), 32'd13);
            check("stall_m_b", 32'(m_b), 32'd22);
        end
        check("stall_no_start", 32'(starts), 32'(s0));
        m_rdy = 1'b1;
        drain(1, 60);
        check("stall_one_start", 32'(starts), 32'(s0 + 1));
        check("hold_m_a_after", 32'(m_a), 32'd13);
        check("hold_m_req_low", 32'(m_req), 32'd0);

        // Timeout: multiplier never answers.
        hang = 1'b1;
        repeat (2) step();
        s0 = starts;
        g0 = got;
        enq(5'd5, 5'd6);
        t = 0;
        while (starts == s0 && t < 20) begin step(); t++; end
        check("tmo_started", 32'(starts), 32'(s0 + 1));
        repeat (TMO - 1) step();
        check("tmo_not_yet", 32'(timeout_err), 32'd0);
        check("tmo_still_wait", 32'(fsm_state), 32'(WAIT));
        step();
        check("tmo_err_set", 32'(timeout_err), 32'd1);
        check("tmo_back_idle", 32'(fsm_state), 32'(IDLE));
        check("tmo_no_out_valid", 32'(out_valid), 32'd0);
        // The timed-out pair produces no result.
        void'(exp_q.pop_back());
        hang = 1'b0;
        enq(5'd2, 5'd3);
        drain(1, 60);
        check("tmo_results", 32'(got), 32'(g0 + 1));
        check("tmo_err_sticky", 32'(timeout_err), 32'd1);

        // Reset mid-WAIT with two pairs queued.
        hang = 1'b1; out_ready = 1'b0; m_rdy = 1'b1;
        repeat (2) step();
        enq(5'd4, 5'd4); enq(5'd8, 5'd9); enq(5'd10, 5'd11);
        t = 0;
        while (!(fsm_state == WAIT && pend_q.size() == 0) && t < 30) begin step(); t++; end
        check("rst_reached_wait", 32'(fsm_state), 32'(WAIT));
        #2 rst = 1'b1;
        #1;
        check("midrst_m_req", 32'(m_req), 32'd0);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_timeout_err", 32'(timeout_err), 32'd0);
        check("midrst_op_count", 32'(op_count), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_m_a", 32'(m_a), 32'd0);
        check("midrst_out_ab", 32'(out_ab), 32'd0);
        check("midrst_state", 32'(fsm_state), 32'(IDLE));
        exp_q.delete();
        pend_q.delete();
        in_valid = 1'b0;
        exp_cnt = 0;
        hang = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;
        g0 = got;
        repeat (40) step();
        check("postrst_no_results", 32'(got), 32'(g0));
        check("postrst_op_count", 32'(op_count), 32'd0);

        // Randomized traffic with random m_rdy and out_ready.
        rdy_rand = 1'b1; ord_rand = 1'b1;
        for (int r = 0; r < 12; r++) begin
            n = $urandom_range(1, 8);
            for (int i = 0; i < n; i++) enq(W'($urandom), W'($urandom));
            drain(n, 80 * n);
        end
        ord_rand = 1'b0; out_ready = 1'b1;
        repeat (5) step();
        check("final_op_count", 32'(op_count), 32'(16'(exp_cnt)));
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        check("final_in_ready", 32'(in_ready), 32'd1);
        check("final_out_valid", 32'(out_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
